// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer sharing one alu_dp: grant -> execute -> respond.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module alu_dp (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] r,
  output logic [3:0]  flags
);
  always_comb begin
    r = 32'd0;
    case (op)
      3'd0:    r = a + b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = 32'd0;
    endcase
  end

  // Unsigned compare: {gt, lt, eq, ne}
  assign flags = {a > b, a < b, a == b, a != b};
endmodule

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_r,
  output logic [3:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic        g_reg;
  logic        winner;
  logic        grant;
  logic        done;
  logic [31:0] alu_r;
  logic [3:0]  alu_flags;

`ifdef ALU_ARB_RR_EN
  logic ptr_reg;

  // On contention the pointer picks; a lone request wins outright.
  assign winner = (req_valid == 2'b11) ? ptr_reg : req_valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (done) begin
      ptr_reg <= ~g_reg;
    end
  end
`else
  assign winner = ~req_valid[0];
`endif

  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    grant      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((|req_valid) && !rst) begin
          grant      = 1'b1;
          req_ready  = winner ? 2'b10 : 2'b01;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= 3'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      g_reg     <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= 32'd0;
      rsp_flags <= 4'd0;
      op_count  <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        op_reg <= winner ? req_op1 : req_op0;
        a_reg  <= winner ? req_a1 : req_a0;
        b_reg  <= winner ? req_b1 : req_b0;
        g_reg  <= winner;
      end
      if (state_reg == EXEC) begin
        rsp_id    <= g_reg;
        rsp_r     <= alu_r;
        rsp_flags <= alu_flags;
      end
      if (done) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

  alu_dp u_alu_dp (
    .op    (op_reg),
    .a     (a_reg),
    .b     (b_reg),
    .r     (alu_r),
    .flags (alu_flags)
  );

  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [2:0]       req_op0, req_op1;
  logic [31:0]      req_a0, req_b0, req_a1, req_b1;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_r;
  logic [3:0]       rsp_flags;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_vec;
  int n_err;

  // Reference model: one transaction in flight at most.
  bit          m_inflight;
  bit          m_in_resp;
  bit          m_id;
  logic [31:0] m_r;
  logic [3:0]  m_flags;
  int          m_count;
  bit          m_ptr;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .rsp_flags (rsp_flags),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    return {a > b, a < b, a == b, a != b};
  endfunction

  function automatic bit ref_winner(input logic [1:0] v);
`ifdef ALU_ARB_RR_EN
    if (v == 2'b11) return m_ptr;
    return v[1];
`else
    return !v[0];
`endif
  endfunction

  task automatic model_reset();
    m_inflight = 0;
    m_in_resp  = 0;
    m_id       = 0;
    m_count    = 0;
    m_ptr      = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model across the edge.
  task automatic step(input logic [1:0] v,
                      input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic rr);
    logic [1:0] exp_ready;
    bit         w;
    @(posedge clk);
    #1;
    req_valid = v;
    req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1;
    rsp_ready = rr;
    #1;
    exp_ready = 2'b00;
    w = 0;
    if (!m_inflight && (|v)) begin
      w = ref_winner(v);
      exp_ready = w ? 2'b10 : 2'b01;
    end
    check("busy", {31'd0, busy}, {31'd0, m_inflight});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_inflight && m_in_resp});
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    check("op_count", {30'd0, op_count}, m_count % (1 << CNT_W));
    if (m_inflight && m_in_resp) begin
      check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      check("rsp_r", rsp_r, m_r);
      check("rsp_flags", {28'd0, rsp_flags}, {28'd0, m_flags});
    end
    if (!m_inflight) begin
      if (|v) begin
        m_inflight = 1;
        m_in_resp  = 0;
        m_id       = w;
        m_r        = w ? ref_result(o1, a1, b1) : ref_result(o0, a0, b0);
        m_flags    = w ? ref_flags(a1, b1) : ref_flags(a0, b0);
      end
    end else if (!m_in_resp) begin
      m_in_resp = 1;
    end else if (rr) begin
      m_count++;
      m_inflight = 0;
      m_in_resp  = 0;
`ifdef ALU_ARB_RR_EN
      m_ptr = !m_id;
`endif
      $display("rsp id=%0d r=0x%08h flags=%04b count=%0d", m_id, m_r, m_flags,
               m_count % (1 << CNT_W));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    check({tag, "_rsp_r"}, rsp_r, 32'd0);
    check({tag, "_rsp_flags"}, {28'd0, rsp_flags}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_op_count"}, {30'd0, op_count}, 32'd0);
  endtask

  initial begin
    logic [1:0]  v;
    logic [2:0]  o0, o1;
    logic [31:0] a0, b0, a1, b1;
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    req_op0 = 3'd0; req_a0 = 32'd0; req_b0 = 32'd0;
    req_op1 = 3'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    rsp_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    #9 rst = 1'b0;

    // Single add from requester 0, then an unused opcode
    step(2'b01, 3'd0, 32'd3, 32'd4, 3'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);
    step(2'b01, 3'd7, 32'd1, 32'd2, 3'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Reset while in EXEC discards the operation, then recovery
    step(2'b10, 3'd3, 32'd0, 32'd0, 3'd0, 32'd9, 32'd9, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    #1 rst = 1'b0;
    step(2'b01, 3'd4, 32'hF0F0, 32'h0FF0, 3'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Continuous contention
    for (int i = 0; i < 12; i++)
      step(2'b11, 3'd2, 32'hF0, 32'h3C, 3'd4, 32'h55, 32'h55, 1'b1);
    step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);
    step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Backpressure: five RESP cycles with rsp_ready low while requester 1 waits
    step(2'b10, 3'd0, 32'd0, 32'd0, 3'd3, 32'h1234, 32'h00FF, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b10, 3'd0, 32'd0, 32'd0, 3'd2, 32'hFFFF, 32'h1, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b10, 3'd0, 32'd0, 32'd0, 3'd2, 32'hFFFF, 32'h1, 1'b1);
    step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);
    step(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      v  = 2'($urandom_range(0, 3));
      o0 = 3'($urandom_range(0, 7));
      o1 = 3'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      b0 = ($urandom_range(0, 3) == 0) ? a0 : (($urandom_range(0, 1) != 0) ? $urandom
                                                : 32'($urandom_range(0, 15)));
      a1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      b1 = ($urandom_range(0, 3) == 0) ? a1 : 32'($urandom_range(0, 15));
      step(v, o0, a0, b0, o1, a1, b1, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
